bcd_convert_arbiter: RTL
========================

# bcd_convert_arbiter

Round-robin scheduler that shares one `double_dabble` binary-to-BCD converter among NUM_REQ requesters, such as the display fields of the keyboard/7-segment front end. It captures the winning requester's binary value and sequences the converter's START/DONE handshake. It then returns the BCD result with a one-cycle acknowledge tagged with the requester index.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- INPUT_WIDTH, 16, binary width per requester (1..255; converter counter is 8 bits)
- DECIMAL_DIGITS, 5, BCD digits produced
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- req  in  NUM_REQ  level request per requester; held high until its ack
- req_binary  in  NUM_REQ*INPUT_WIDTH  requester i value at bits [i*INPUT_WIDTH +: INPUT_WIDTH]
- ack  out  NUM_REQ  one-hot, one-cycle pulse: result for requester i valid on bcd_out
- ack_id  out  clog2(NUM_REQ)  index of the acknowledged requester, valid with ack
- bcd_out  out  DECIMAL_DIGITS*4  BCD result, held until next ack
- busy  out  1  high from grant until the ack cycle inclusive

## Operation
- FSM states: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: if any req is high, grant the first requester found searching from last_grant+1 cyclically. Register grant_id and the granted req_binary slice. Set last_grant=grant_id and go to ISSUE.
- ISSUE: drive converter START=1 for exactly this cycle with the captured value. Go to WAIT.
- WAIT: converter DONE is low while it runs. On the first cycle DONE=1, register converter BCD into bcd_out and go to DELIVER.
- DELIVER: ack[grant_id]=1, ack_id=grant_id. Return to IDLE.
- START is low in every state except ISSUE.
- Requester drops req before grant: the request is withdrawn and gets no ack. Drops req after grant: the conversion completes and ack still pulses.
- A requester that re-asserts req right after its ack waits behind all other pending requesters.
- Reset: state=IDLE, last_grant=NUM_REQ-1 so requester 0 wins first, ack=0, ack_id=0, bcd_out=0, busy=0.
- The converter shares resetn, so reset mid-conversion aborts both blocks cleanly and produces no ack.

## Timing
- Request seen in IDLE at cycle 0 (no cache hit):
  - grant is registered at cycle 0 and busy rises at cycle 1;
  - ISSUE is cycle 1;
  - converter DONE is first high at cycle INPUT_WIDTH+2;
  - ack is high at cycle INPUT_WIDTH+3.
- With the default INPUT_WIDTH=16, ack is at cycle 19.
- Back-to-back: the next grant is evaluated in the IDLE cycle right after DELIVER, giving one conversion per INPUT_WIDTH+4 cycles.
- All outputs are registered. No combinational path from req to ack.

## Configuration
- BCD_ARB_CACHE_EN defined:
  - Per-requester storage of last binary value, last BCD, and a valid bit; valid bits clear on reset.
  - In IDLE, if the granted requester's req_binary equals its cached value and valid=1, skip ISSUE/WAIT and go to DELIVER with the cached BCD. ack appears at cycle 2.
  - Every converter completion updates the granted requester's cache.
- Undefined: no cache storage; every grant runs the converter.

## Structure
- Package bcd_arb_pkg holds the FSM state encoding (IDLE/ISSUE/WAIT/DELIVER) and the localparam for the id width.
- One sub-module is natural: rr_arbiter (NUM_REQ, req vector + last_grant in, grant_id + any_req out, combinational).
- The block instantiates one double_dabble with INPUT_WIDTH/DECIMAL_DIGITS passed through.

## Test plan
- Single request, req[0] with value 16'd9999 held -> ack[0] at cycle 19, bcd_out=20'h09999, ack_id=0, busy high cycles 1..19.
- All four req high with values 1,22,333,4444 -> acks in order 0,1,2,3, each 20 cycles apart, bcd_out 00001, 00022, 00333, 04444.
- Fairness: req[1] re-asserted immediately after each ack while req[2] is held -> grants alternate 1,2,1,2.
- Withdrawal: req[3] pulsed for 1 cycle while the converter is busy serving req[0] -> no ack[3] ever.
- resetn low at cycle 8 of a conversion for 65535 -> no ack; all outputs 0; next request converts correctly (bcd_out=20'h65535).
- BCD_ARB_CACHE_EN: req[2]=16'd1234 twice -> first ack at cycle 19, second ack 2 cycles after its grant, bcd_out=20'h01234, START never pulses on the second request.

Source files
------------

// File: rtl/bcd_arb_pkg.sv
// Shared types for the BCD converter arbiter: FSM encoding and id sizing.
// Build option BCD_ARB_CACHE_EN adds a per-requester result cache.
package bcd_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DELIVER
   } arb_state_e;

   function automatic int unsigned id_w(input int unsigned n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int unsigned DEF_NUM_REQ = 4;
   localparam int unsigned DEF_ID_W    = id_w(DEF_NUM_REQ);

endpackage

// File: rtl/bcd_convert_arbiter_rr.sv
// Combinational round-robin pick: first set req after last_grant, wrapping.
module rr_arbiter
   import bcd_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [ID_W-1:0]    last_grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any_req
);

   logic [ID_W-1:0] idx;

   // Scan farthest-first so the nearest candidate overwrites last.
   always_comb begin
      grant_id = '0;
      idx      = '0;
      for (int i = int'(NUM_REQ); i >= 1; i--) begin
         idx = ID_W'((int'(last_grant) + i) % int'(NUM_REQ));
         if (req[idx]) grant_id = idx;
      end
      any_req = |req;
   end

endmodule

// File: rtl/double_dabble.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per cycle.
// done rises the cycle after the last shift and holds until the next start.
module double_dabble #(
   parameter int unsigned INPUT_WIDTH    = 16,
   parameter int unsigned DECIMAL_DIGITS = 5
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic                          start,
   input  logic [INPUT_WIDTH-1:0]        binary_in,
   output logic                          done,
   output logic [DECIMAL_DIGITS*4-1:0]   bcd_out
);

   localparam int unsigned BW = DECIMAL_DIGITS * 4;

   logic [INPUT_WIDTH-1:0] bin_q, bin_d;
   logic [BW-1:0]          bcd_q, bcd_d, adj;
   logic [7:0]             cnt_q, cnt_d;
   logic                   run_q, run_d;
   logic                   done_q, done_d;

   always_comb begin
      adj = '0;
      for (int d = 0; d < int'(DECIMAL_DIGITS); d++) begin
         adj[d*4 +: 4] = (bcd_q[d*4 +: 4] >= 4'd5) ?
                         bcd_q[d*4 +: 4] + 4'd3 : bcd_q[d*4 +: 4];
      end
      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      run_d  = run_q;
      done_d = done_q;
      if (start) begin
         bin_d  = binary_in;
         bcd_d  = '0;
         cnt_d  = 8'(INPUT_WIDTH);
         run_d  = 1'b1;
         done_d = 1'b0;
      end else if (run_q) begin
         bin_d = bin_q << 1;
         bcd_d = {adj[BW-2:0], bin_q[INPUT_WIDTH-1]};
         cnt_d = cnt_q - 8'd1;
         if (cnt_q == 8'd1) begin
            run_d  = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         run_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         done_q <= done_d;
      end
   end

   assign done    = done_q;
   assign bcd_out = bcd_q;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Shares one double_dabble converter among NUM_REQ round-robin requesters.
// Define BCD_ARB_CACHE_EN to reuse the last result when a value repeats.
module bcd_convert_arbiter
   import bcd_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned INPUT_WIDTH    = 16,
   parameter int unsigned DECIMAL_DIGITS = 5,
   localparam int unsigned ID_W          = id_w(NUM_REQ)
) (
   input  logic                              clk,
   input  logic                              resetn,
   input  logic [NUM_REQ-1:0]                req,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0]    req_binary,
   output logic [NUM_REQ-1:0]                ack,
   output logic [ID_W-1:0]                   ack_id,
   output logic [DECIMAL_DIGITS*4-1:0]       bcd_out,
   output logic                              busy
);

   localparam int unsigned BW = DECIMAL_DIGITS * 4;

   arb_state_e             state_q, state_d;
   logic [ID_W-1:0]        grant_q, grant_d;
   logic [ID_W-1:0]        last_q, last_d;
   logic [INPUT_WIDTH-1:0] bin_q, bin_d, sel_bin;
   logic [BW-1:0]          bcd_q, bcd_d, conv_bcd;
   logic [NUM_REQ-1:0]     ack_q, ack_d;
   logic [ID_W-1:0]        ack_id_q, ack_id_d;
   logic                   busy_q, busy_d;
   logic [ID_W-1:0]        arb_id;
   logic                   any_req, conv_start, conv_done;

`ifdef BCD_ARB_CACHE_EN
   logic                   hit_q, hit_d;
   logic [INPUT_WIDTH-1:0] cbin_q [NUM_REQ];
   logic [INPUT_WIDTH-1:0] cbin_d [NUM_REQ];
   logic [BW-1:0]          cbcd_q [NUM_REQ];
   logic [BW-1:0]          cbcd_d [NUM_REQ];
   logic [NUM_REQ-1:0]     cval_q, cval_d;

   assign conv_start = (state_q == ST_ISSUE) && !hit_q;
`else
   assign conv_start = (state_q == ST_ISSUE);
`endif

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
      .req        (req),
      .last_grant (last_q),
      .grant_id   (arb_id),
      .any_req    (any_req)
   );

   double_dabble #(
      .INPUT_WIDTH    (INPUT_WIDTH),
      .DECIMAL_DIGITS (DECIMAL_DIGITS)
   ) u_dd (
      .clk       (clk),
      .resetn    (resetn),
      .start     (conv_start),
      .binary_in (bin_q),
      .done      (conv_done),
      .bcd_out   (conv_bcd)
   );

   always_comb begin
      sel_bin = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (arb_id == ID_W'(i)) sel_bin = req_binary[i*INPUT_WIDTH +: INPUT_WIDTH];
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      bin_d    = bin_q;
      bcd_d    = bcd_q;
      ack_d    = '0;
      ack_id_d = ack_id_q;
      busy_d   = busy_q;
`ifdef BCD_ARB_CACHE_EN
      hit_d  = hit_q;
      cbin_d = cbin_q;
      cbcd_d = cbcd_q;
      cval_d = cval_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               grant_d = arb_id;
               last_d  = arb_id;
               bin_d   = sel_bin;
               busy_d  = 1'b1;
               state_d = ST_ISSUE;
`ifdef BCD_ARB_CACHE_EN
               hit_d = cval_q[arb_id] && (cbin_q[arb_id] == sel_bin);
`endif
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef BCD_ARB_CACHE_EN
            if (hit_q) begin
               bcd_d          = cbcd_q[grant_q];
               ack_d[grant_q] = 1'b1;
               ack_id_d       = grant_q;
               state_d        = ST_DELIVER;
            end
`endif
         end
         ST_WAIT: begin
            if (conv_done) begin
               bcd_d          = conv_bcd;
               ack_d[grant_q] = 1'b1;
               ack_id_d       = grant_q;
               state_d        = ST_DELIVER;
`ifdef BCD_ARB_CACHE_EN
               cbin_d[grant_q] = bin_q;
               cbcd_d[grant_q] = conv_bcd;
               cval_d[grant_q] = 1'b1;
`endif
            end
         end
         ST_DELIVER: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= ST_IDLE;
         grant_q  <= '0;
         last_q   <= ID_W'(NUM_REQ - 1);
         bin_q    <= '0;
         bcd_q    <= '0;
         ack_q    <= '0;
         ack_id_q <= '0;
         busy_q   <= 1'b0;
`ifdef BCD_ARB_CACHE_EN
         hit_q    <= 1'b0;
         cval_q   <= '0;
`endif
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         bin_q    <= bin_d;
         bcd_q    <= bcd_d;
         ack_q    <= ack_d;
         ack_id_q <= ack_id_d;
         busy_q   <= busy_d;
`ifdef BCD_ARB_CACHE_EN
         hit_q    <= hit_d;
         cval_q   <= cval_d;
`endif
      end
   end

`ifdef BCD_ARB_CACHE_EN
   // Cache payload needs no reset; the valid bits gate it.
   always_ff @(posedge clk) begin
      cbin_q <= cbin_d;
      cbcd_q <= cbcd_d;
   end
`endif

   assign ack     = ack_q;
   assign ack_id  = ack_id_q;
   assign bcd_out = bcd_q;
   assign busy    = busy_q;

endmodule
